uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, meaning sys_clk frequency in MHz.
REQ-002 SHALL have parameter TIMEOUT_US, default 1000, meaning maximum allowed inter-byte gap in microseconds.
REQ-003 SHALL have parameter HEADER, default 8'hA5, meaning frame start byte.
REQ-004 SHALL have port sys_clk, input, 1, system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port byte_valid, input, 1, one-cycle strobe from the UART receiver marking byte_data valid.
REQ-007 SHALL have port byte_data, input, 8, received byte, sampled only when byte_valid=1.
REQ-008 SHALL have port cmd_valid, output, 1, one-cycle strobe marking a good frame.
REQ-009 SHALL have port cmd_code, output, 8, command byte of the last good frame.
REQ-010 SHALL have port cmd_param, output, 16, parameter of the last good frame as {param_hi, param_lo}.
REQ-011 SHALL have port frame_err, output, 1, one-cycle strobe on a checksum error or timeout.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL use a five-byte frame: HEADER, cmd, param_hi, param_lo, chk, where chk = cmd XOR param_hi XOR param_lo.
REQ-014 SHALL implement a one-hot FSM with states IDLE, CMD, PH, PL and CHK.
REQ-015 SHALL transition IDLE->CMD on byte_valid with byte_data==HEADER; any other byte in IDLE SHALL be discarded.
REQ-016 SHALL advance CMD->PH->PL->CHK, one state per byte_valid, latching each byte into internal holding registers.
REQ-017 SHALL, in CHK on byte_valid, compare byte_data against the running XOR and then return to IDLE.
REQ-018 SHALL, on a checksum match, pulse cmd_valid and update cmd_code/cmd_param in the cycle after the CHK byte_valid (latency 1).
REQ-019 SHALL, on a checksum mismatch, pulse frame_err in the cycle after the CHK byte_valid and leave cmd_code/cmd_param unchanged.
REQ-020 SHALL treat a HEADER value arriving in CMD/PH/PL/CHK as an ordinary data byte (no resync).
REQ-021 SHALL keep a 16-bit gap counter that clears on every byte_valid and increments each cycle while not IDLE, saturating at the limit.
REQ-022 SHALL set the gap limit to CLK_FRE*TIMEOUT_US-1 (default 49999); in IDLE the counter SHALL be held at 0.
REQ-023 SHALL, when the gap counter reaches the limit with byte_valid=0, return to IDLE and pulse frame_err one cycle later.
REQ-024 SHALL let byte_valid win when it coincides with the timeout cycle: the byte is accepted and no timeout occurs.
REQ-025 SHALL never assert cmd_valid and frame_err in the same cycle.
REQ-026 SHALL accept back-to-back frames with zero idle cycles between byte_valid strobes.

Reset
REQ-027 SHALL, while sys_rst_n=0, force the state to IDLE and zero cmd_valid, frame_err, cmd_code, cmd_param, the gap counter and the holding registers.
REQ-028 SHALL make busy=0 during reset.
REQ-029 SHALL discard a partial frame on reset mid-frame, with no strobe emitted after reset release.

Structure
REQ-030 SHALL place the state encodings, default HEADER and frame length constant in shared package uart_cmd_pkg.
REQ-031 SHALL be a single flat module with no sub-module; the gap counter stays inline.

Verification
REQ-032 SHALL verify: bytes A5,10,12,34,36 -> cmd_valid for one cycle, cmd_code=10, cmd_param=1234, frame_err=0.
REQ-033 SHALL verify: bytes A5,10,12,34,37 -> frame_err for one cycle, cmd_code/cmd_param keep their prior values.
REQ-034 SHALL verify: bytes 00,FF,A5,01,00,02,03 -> leading bytes ignored, cmd_valid with cmd_code=01, cmd_param=0002.
REQ-035 SHALL verify: A5,10 then a 50000-cycle gap -> frame_err, busy=0; a following good frame decodes normally.
REQ-036 SHALL verify: a byte_valid exactly on the limit cycle -> no frame_err, and the frame completes.
REQ-037 SHALL verify: reset asserted after A5,10,12 -> all outputs zero; after release, bytes 34,36 produce no strobe.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command frame parser.
//   state_e       : one-hot parser states
//   DefaultHeader : frame start byte used unless overridden
//   FrameLen      : bytes per frame (header, cmd, param_hi, param_lo, chk)
package uart_cmd_pkg;

   typedef enum logic [4:0] {
      StIdle = 5'b00001,
      StCmd  = 5'b00010,
      StPh   = 5'b00100,
      StPl   = 5'b01000,
      StChk  = 5'b10000
   } state_e;

   localparam logic [7:0]  DefaultHeader = 8'hA5;
   localparam int unsigned FrameLen      = 5;

endpackage

// File: rtl/uart_cmd_parser.sv
// Parses five-byte command frames from a UART byte stream:
//   HEADER, cmd, param_hi, param_lo, chk   with chk = cmd ^ param_hi ^ param_lo
// A frame is abandoned if the gap between bytes exceeds TIMEOUT_US.
//
// Ports
//   sys_clk    : system clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   byte_valid : one-cycle strobe qualifying byte_data
//   byte_data  : received byte
//   cmd_valid  : one-cycle strobe for a frame with a good checksum
//   cmd_code   : command byte of the last good frame
//   cmd_param  : {param_hi, param_lo} of the last good frame
//   frame_err  : one-cycle strobe on checksum error or inter-byte timeout
//   busy       : high while a frame is in progress
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned CLK_FRE    = 50,
   parameter int unsigned TIMEOUT_US = 1000,
   parameter logic [7:0]  HEADER     = DefaultHeader
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd_code,
   output logic [15:0] cmd_param,
   output logic        frame_err,
   output logic        busy
);

   localparam int unsigned GapLimitInt = CLK_FRE * TIMEOUT_US - 1;
   localparam logic [15:0] GapLimit    = 16'(GapLimitInt);

   state_e      state_q;
   logic [15:0] gap_cnt_q;
   logic [7:0]  cmd_q;
   logic [7:0]  ph_q;
   logic [7:0]  pl_q;
   logic [7:0]  xor_q;

   logic timeout;

   // A byte arriving on the limit cycle takes priority over the timeout.
   assign timeout = (state_q != StIdle) && !byte_valid && (gap_cnt_q == GapLimit);
   assign busy    = (state_q != StIdle);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= StIdle;
         gap_cnt_q <= '0;
         cmd_q     <= '0;
         ph_q      <= '0;
         pl_q      <= '0;
         xor_q     <= '0;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         cmd_code  <= '0;
         cmd_param <= '0;
      end else begin
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;

         // Gap counter: cleared by every byte, held at zero in IDLE, saturating.
         if (byte_valid || (state_q == StIdle)) begin
            gap_cnt_q <= '0;
         end else if (gap_cnt_q != GapLimit) begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
         end

         if (timeout) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            frame_err <= 1'b1;
         end else if (byte_valid) begin
            unique case (state_q)
               StIdle: begin
                  if (byte_data == HEADER) begin
                     state_q <= StCmd;
                  end
               end
               StCmd: begin
                  cmd_q   <= byte_data;
                  xor_q   <= byte_data;
                  state_q <= StPh;
               end
               StPh: begin
                  ph_q    <= byte_data;
                  xor_q   <= xor_q ^ byte_data;
                  state_q <= StPl;
               end
               StPl: begin
                  pl_q    <= byte_data;
                  xor_q   <= xor_q ^ byte_data;
                  state_q <= StChk;
               end
               StChk: begin
                  if (byte_data == xor_q) begin
                     cmd_valid <= 1'b1;
                     cmd_code  <= cmd_q;
                     cmd_param <= {ph_q, pl_q};
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized scoreboard bench for uart_cmd_parser. A frame-level reference
// model predicts each strobe; a monitor compares whatever the DUT presents.
module tb_uart_cmd_parser;
   import uart_cmd_pkg::*;

   localparam int unsigned ClkFre    = 1;
   localparam int unsigned TimeoutUs = 20;
   localparam int unsigned Limit     = ClkFre * TimeoutUs - 1;
   localparam logic [7:0]  Hdr       = 8'hA5;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        cmd_valid;
   logic [7:0]  cmd_code;
   logic [15:0] cmd_param;
   logic        frame_err;
   logic        busy;

   uart_cmd_parser #(
      .CLK_FRE    (ClkFre),
      .TIMEOUT_US (TimeoutUs),
      .HEADER     (Hdr)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code),
      .cmd_param  (cmd_param),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      bit          err;
      logic [7:0]  code;
      logic [15:0] param;
      int          cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] frame[$];
   int         since;
   int         cyc;
   logic [7:0] m_code;
   logic [15:0] m_param;
   int         n_tests;
   int         n_fail;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Frame-level model: collect bytes after a header, judge the frame when complete.
   task automatic model_byte(input logic [7:0] b);
      exp_t e;
      if (frame.size() == 0) begin
         if (b == Hdr) frame.push_back(b);
      end else begin
         frame.push_back(b);
         if (frame.size() == FrameLen) begin
            if ((frame[1] ^ frame[2] ^ frame[3]) == frame[4]) begin
               m_code  = frame[1];
               m_param = {frame[2], frame[3]};
               e.err   = 1'b0;
            end else begin
               e.err = 1'b1;
            end
            e.code  = m_code;
            e.param = m_param;
            e.cyc   = cyc + 1;
            exp_q.push_back(e);
            frame.delete();
         end
      end
   endtask

   always @(posedge sys_clk) begin
      exp_t e;
      if (!sys_rst_n) begin
         frame.delete();
         since   = 0;
         m_code  = '0;
         m_param = '0;
      end else if (byte_valid) begin
         since = 0;
         model_byte(byte_data);
      end else if (frame.size() != 0) begin
         since++;
         if (since == int'(Limit) + 1) begin
            e.err   = 1'b1;
            e.code  = m_code;
            e.param = m_param;
            e.cyc   = cyc + 1;
            exp_q.push_back(e);
            frame.delete();
         end
      end
      cyc++;
   end

   always @(negedge sys_clk) begin
      exp_t e;
      if (sys_rst_n) begin
         check("busy", {31'd0, busy}, {31'd0, frame.size() != 0});
         while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_strobe: got none expected err=%0d at cycle %0d", e.err, e.cyc);
         end
         if (cmd_valid || frame_err) begin
            check("exclusive", {31'd0, cmd_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_strobe: got cmd_valid=%0d frame_err=%0d expected none",
                        cmd_valid, frame_err);
            end else begin
               e = exp_q.pop_front();
               check("kind_err", {31'd0, frame_err}, {31'd0, e.err});
               check("cmd_code", {24'd0, cmd_code}, {24'd0, e.code});
               check("cmd_param", {16'd0, cmd_param}, {16'd0, e.param});
               check("latency", e.cyc, cyc);
            end
         end
      end
   end

   // Called at posedge+1; drives a one-cycle strobe followed by gap idle cycles.
   task automatic send(input logic [7:0] b, input int gap);
      byte_valid = 1'b1;
      byte_data  = b;
      @(posedge sys_clk);
      #1;
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      repeat (gap) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
      check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
      check({tag, "_cmd_code"}, {24'd0, cmd_code}, 32'd0);
      check({tag, "_cmd_param"}, {16'd0, cmd_param}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   int gap;
   logic [7:0] c, ph, pl, k;

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      cyc        = 0;
      since      = 0;
      sys_rst_n  = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      @(negedge sys_clk);
      check_zero("reset");
      idle(3);
      sys_rst_n = 1'b1;
      idle(2);

      // Good frame, back-to-back bytes.
      send(8'hA5, 0); send(8'h10, 0); send(8'h12, 0); send(8'h34, 0); send(8'h36, 3);
      // Bad checksum: outputs keep 10/1234.
      send(8'hA5, 0); send(8'h10, 0); send(8'h12, 0); send(8'h34, 0); send(8'h37, 3);
      // Leading junk discarded.
      send(8'h00, 0); send(8'hFF, 0); send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
      send(8'h02, 0); send(8'h03, 3);
      // Timeout after A5,10, then a good frame.
      send(8'hA5, 1); send(8'h10, Limit + 5);
      send(8'hA5, 0); send(8'h20, 0); send(8'h01, 0); send(8'h02, 0); send(8'h23, 3);
      // Byte exactly on the limit cycle is accepted.
      send(8'hA5, Limit); send(8'h44, Limit); send(8'h55, 0); send(8'h66, Limit);
      send(8'h44 ^ 8'h55 ^ 8'h66, 3);
      // One cycle later it times out.
      send(8'hA5, Limit + 1); send(8'h44, 3);
      // Header inside the payload is ordinary data.
      send(8'hA5, 0); send(8'hA5, 0); send(8'hA5, 0); send(8'h00, 0); send(8'h00, 3);

      // Reset mid-frame discards the partial frame.
      send(8'hA5, 0); send(8'h10, 0); send(8'h12, 0);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      check_zero("midreset");
      idle(3);
      sys_rst_n = 1'b1;
      idle(2);
      send(8'h34, 0); send(8'h36, 5);

      // Randomized frames with junk, corrupted checksums and boundary gaps.
      for (int i = 0; i < 150; i++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) send(8'($urandom), 0);
         c  = 8'($urandom);
         ph = 8'($urandom);
         pl = 8'($urandom);
         k  = c ^ ph ^ pl;
         if ($urandom_range(0, 3) == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
         for (int j = 0; j < 5; j++) begin
            case ($urandom_range(0, 9))
               6:       gap = $urandom_range(1, 3);
               7:       gap = Limit;
               8:       gap = Limit + 1;
               9:       gap = Limit + $urandom_range(2, 6);
               default: gap = 0;
            endcase
            case (j)
               0:       send(Hdr, gap);
               1:       send(c, gap);
               2:       send(ph, gap);
               3:       send(pl, gap);
               default: send(k, gap);
            endcase
         end
      end

      idle(Limit + 10);
      check("drain", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
